// File: rtl/multi_pulse_generator.sv
// multi_pulse_generator: one shared period counter driving N_CHANNELS gated
// outputs, each with its own delay and width inside the period. Supports
// continuous and burst operation. Configuration is captured into shadow
// registers on the run start and at every period boundary.
// Optional feature: define MULTI_PULSE_GENERATOR_POLARITY_EN to add a
// per-channel pulse_polarity input that inverts the matching valid output.
module multi_pulse_generator #(
  parameter int N_CHANNELS         = 2,
  parameter int PULSE_WIDTH_WIDTH  = 8,
  parameter int PULSE_PERIOD_WIDTH = 16,
  parameter int BURST_WIDTH        = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     enable,
  input  logic                                     mode,
  input  logic                                     trigger,
  input  logic [PULSE_PERIOD_WIDTH-1:0]            pulse_period,
  input  logic [BURST_WIDTH-1:0]                   burst_count,
  input  logic [N_CHANNELS*PULSE_PERIOD_WIDTH-1:0] pulse_delay,
  input  logic [N_CHANNELS*PULSE_WIDTH_WIDTH-1:0]  pulse_width,
`ifdef MULTI_PULSE_GENERATOR_POLARITY_EN
  input  logic [N_CHANNELS-1:0]                    pulse_polarity,
`endif
  output logic [N_CHANNELS-1:0]                    valid,
  output logic                                     start,
  output logic [PULSE_PERIOD_WIDTH-1:0]            cnt,
  output logic                                     busy,
  output logic                                     done
);

  localparam int PPW = PULSE_PERIOD_WIDTH;
  localparam int PWW = PULSE_WIDTH_WIDTH;
  localparam int BW  = BURST_WIDTH;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [PPW-1:0] PERIOD_ONE = PPW'(1);
  localparam logic [BW-1:0]  BURST_ONE  = BW'(1);

  logic [0:0]                state;
  logic [PPW-1:0]            counter;
  logic [BW-1:0]             period_num;
  logic [PPW-1:0]            period_sh;
  logic [BW-1:0]             burst_sh;
  logic [N_CHANNELS*PPW-1:0] delay_sh;
  logic [N_CHANNELS*PWW-1:0] width_sh;
  logic                      mode_sh;

  logic [PPW-1:0]            period_eff;
  logic                      at_wrap;
  logic [BW:0]               periods_next;
  logic                      burst_last;
  logic                      run_start;
  logic                      run_stop;
  logic                      load_first;
  logic                      load_shadow;
  logic [N_CHANNELS-1:0]     in_window;
  logic [N_CHANNELS-1:0]     run_pol;
  logic [N_CHANNELS-1:0]     idle_pol;

  // A programmed period of zero behaves like a one-cycle period
  assign period_eff   = (period_sh == '0) ? PERIOD_ONE : period_sh;
  assign at_wrap      = (counter == (period_eff - PERIOD_ONE));
  assign periods_next = {1'b0, period_num} + {{BW{1'b0}}, 1'b1};
  assign burst_last   = (periods_next >= {1'b0, burst_sh});

  assign run_start   = enable && (!mode || (trigger && (burst_count != '0)));
  assign run_stop    = !enable || (mode_sh && burst_last);
  assign load_first  = (state == IDLE) && run_start;
  assign load_shadow = load_first || ((state == RUN) && at_wrap);

  // The delay + width end point is one bit wider than the counter so it never wraps
  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_window
    logic [PPW-1:0] ch_delay;
    logic [PPW:0]   ch_end;
    assign ch_delay     = delay_sh[i*PPW +: PPW];
    assign ch_end       = {1'b0, ch_delay} + {{(PPW+1-PWW){1'b0}}, width_sh[i*PWW +: PWW]};
    assign in_window[i] = (counter >= ch_delay) && ({1'b0, counter} < ch_end);
  end

`ifdef MULTI_PULSE_GENERATOR_POLARITY_EN
  logic [N_CHANNELS-1:0] polarity_sh;

  // Polarity is shadowed at the same instants as the rest of the configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      polarity_sh <= '0;
    end else if (load_shadow) begin
      polarity_sh <= pulse_polarity;
    end
  end

  assign run_pol  = polarity_sh;
  assign idle_pol = pulse_polarity;
`else
  assign run_pol  = '0;
  assign idle_pol = '0;
`endif

  // Run/idle sequencing, the in-period counter and the completed-period count
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= '0;
      period_num <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run_start) begin
            state      <= RUN;
            counter    <= '0;
            period_num <= '0;
          end
        end
        default: begin
          if (at_wrap) begin
            counter    <= '0;
            period_num <= period_num + BURST_ONE;
            if (run_stop) begin
              state <= IDLE;
            end
          end else begin
            counter <= counter + PERIOD_ONE;
          end
        end
      endcase
    end
  end

  // Shadow configuration; mode is only captured when a run begins
  always_ff @(posedge clk) begin
    if (rst) begin
      period_sh <= '0;
      burst_sh  <= '0;
      delay_sh  <= '0;
      width_sh  <= '0;
      mode_sh   <= 1'b0;
    end else begin
      if (load_shadow) begin
        period_sh <= pulse_period;
        burst_sh  <= burst_count;
        delay_sh  <= pulse_delay;
        width_sh  <= pulse_width;
      end
      if (load_first) begin
        mode_sh <= mode;
      end
    end
  end

  // Registered outputs, one cycle behind the internal counter
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= idle_pol;
      start <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (state == RUN) begin
      valid <= in_window ^ run_pol;
      start <= (counter == '0);
      cnt   <= counter;
      busy  <= 1'b1;
      done  <= at_wrap && run_stop && mode_sh;
    end else begin
      valid <= idle_pol;
      start <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// tb_multi_pulse_generator: directed and randomized checking of
// multi_pulse_generator against a cycle-level behavioural model.
module tb_multi_pulse_generator;

  localparam int N   = 2;
  localparam int PWW = 8;
  localparam int PPW = 16;
  localparam int BW  = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               mode;
  logic               trigger;
  logic [PPW-1:0]     pulse_period;
  logic [BW-1:0]      burst_count;
  logic [N*PPW-1:0]   pulse_delay;
  logic [N*PWW-1:0]   pulse_width;
  logic [N-1:0]       valid;
  logic               start;
  logic [PPW-1:0]     cnt;
  logic               busy;
  logic               done;

  // Free-running clock
  always #5 clk = ~clk;

  multi_pulse_generator #(
    .N_CHANNELS(N),
    .PULSE_WIDTH_WIDTH(PWW),
    .PULSE_PERIOD_WIDTH(PPW),
    .BURST_WIDTH(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .mode(mode),
    .trigger(trigger),
    .pulse_period(pulse_period),
    .burst_count(burst_count),
    .pulse_delay(pulse_delay),
    .pulse_width(pulse_width),
    .valid(valid),
    .start(start),
    .cnt(cnt),
    .busy(busy),
    .done(done)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: run flag, position in period, completed periods, active config
  bit m_run;
  bit m_burst;
  int m_k;
  int m_periods;
  int m_per;
  int m_bc;
  int m_dly [N];
  int m_wid [N];

  logic [N-1:0]   e_valid;
  logic           e_start;
  logic           e_busy;
  logic           e_done;
  logic [PPW-1:0] e_cnt;

  // Observation tallies for the directed literal checks
  int n_busy  = 0;
  int n_start = 0;
  int n_done  = 0;
  int n_done4 = 0;
  int n_v [N] = '{0, 0};

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit md, input int per, input int bc,
                               input int d0, input int d1, input int w0, input int w1);
    enable       = en;
    mode         = md;
    pulse_period = PPW'(per);
    burst_count  = BW'(bc);
    pulse_delay  = {PPW'(d1), PPW'(d0)};
    pulse_width  = {PWW'(w1), PWW'(w0)};
  endtask

  task automatic loadCfg();
    m_per = int'(pulse_period);
    m_bc  = int'(burst_count);
    for (int i = 0; i < N; i++) begin
      m_dly[i] = int'(pulse_delay[i*PPW +: PPW]);
      m_wid[i] = int'(pulse_width[i*PWW +: PWW]);
    end
  endtask

  // What the outputs must show after this clock edge, given the inputs now
  task automatic modelStep();
    int  p;
    bit  stop;
    e_valid = '0;
    e_start = 1'b0;
    e_busy  = 1'b0;
    e_done  = 1'b0;
    e_cnt   = '0;
    if (rst) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (enable && (!mode || (trigger && burst_count != '0))) begin
        m_run     = 1'b1;
        m_burst   = mode;
        m_k       = 0;
        m_periods = 0;
        loadCfg();
      end
    end else begin
      e_cnt   = PPW'(m_k);
      e_start = (m_k == 0);
      e_busy  = 1'b1;
      for (int i = 0; i < N; i++) begin
        e_valid[i] = (m_k >= m_dly[i]) && (m_k < m_dly[i] + m_wid[i]);
      end
      p = (m_per == 0) ? 1 : m_per;
      if (m_k == p - 1) begin
        m_periods++;
        stop = !enable || (m_burst && m_periods >= m_bc);
        if (stop) begin
          m_run  = 1'b0;
          e_done = m_burst;
        end
        loadCfg();
        m_k = 0;
      end else begin
        m_k++;
      end
    end
  endtask

  // One clock: advance the model at the edge, compare and tally at the falling edge
  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checks++;
    if ({valid, start, busy, done, cnt} !== {e_valid, e_start, e_busy, e_done, e_cnt}) begin
      errors++;
      $display("[TB] FAIL cycle @%0t: got valid=%b start=%b busy=%b done=%b cnt=%0d, expected valid=%b start=%b busy=%b done=%b cnt=%0d",
               $time, valid, start, busy, done, cnt, e_valid, e_start, e_busy, e_done, e_cnt);
    end
    n_busy  += int'(busy);
    n_start += int'(start);
    n_done  += int'(done);
    n_done4 += int'(done && (cnt == PPW'(4)));
    for (int i = 0; i < N; i++) n_v[i] += int'(valid[i]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic waitCnt(input int value, input int bound);
    bit found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      tick();
      if (busy && cnt == PPW'(value)) found = 1'b1;
    end
    checkOutput($sformatf("wait_cnt_%0d", value), int'(found), 1);
  endtask

  task automatic waitStart(input int bound, output int cycles);
    bit found = 1'b0;
    cycles = 0;
    for (int i = 0; i < bound && !found; i++) begin
      tick();
      cycles++;
      if (start) found = 1'b1;
    end
    checkOutput("wait_start", int'(found), 1);
  endtask

  initial begin
    int b_busy, b_start, b_done, b_done4, b_v0, b_v1;
    int c, last, nb;
    bit found;

    rst     = 1'b1;
    trigger = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    ticks(2);
    checkOutput("reset_state", int'({valid, start, busy, done, cnt}), 0);
    rst = 1'b0;

    $display("[TB] continuous basic");
    applyStimulus(1'b1, 1'b0, 10, 0, 0, 3, 2, 4);
    ticks(5);
    b_start = n_start; b_v0 = n_v[0]; b_v1 = n_v[1];
    ticks(30);
    checkOutput("cont_starts", n_start - b_start, 3);
    checkOutput("cont_valid0_high", n_v[0] - b_v0, 6);
    checkOutput("cont_valid1_high", n_v[1] - b_v1, 12);

    $display("[TB] shadowing");
    waitCnt(4, 20);
    applyStimulus(1'b1, 1'b0, 6, 0, 0, 3, 5, 4);
    waitStart(20, c);
    checkOutput("shadow_old_period_len", c, 6);
    b_v0 = n_v[0]; b_v1 = n_v[1];
    waitStart(20, c);
    checkOutput("shadow_new_period_len", c, 6);
    checkOutput("shadow_new_width0", n_v[0] - b_v0, 5);
    checkOutput("shadow_trunc_valid1", n_v[1] - b_v1, 3);

    $display("[TB] continuous stop");
    applyStimulus(1'b1, 1'b0, 8, 0, 0, 3, 2, 4);
    waitCnt(7, 30);
    waitCnt(3, 30);
    enable = 1'b0;
    b_done = n_done;
    last = -1; nb = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (busy) begin
        last = int'(cnt);
        nb++;
      end else begin
        found = 1'b1;
      end
    end
    checkOutput("stop_reached_idle", int'(found), 1);
    checkOutput("stop_last_cnt", last, 7);
    checkOutput("stop_busy_after_drop", nb, 4);
    checkOutput("stop_no_done", n_done - b_done, 0);

    $display("[TB] burst");
    applyStimulus(1'b1, 1'b1, 5, 3, 0, 3, 2, 4);
    ticks(2);
    b_busy = n_busy; b_start = n_start; b_done = n_done; b_done4 = n_done4;
    trigger = 1'b1; tick(); trigger = 1'b0;
    ticks(6);
    trigger = 1'b1; tick(); trigger = 1'b0;
    ticks(25);
    checkOutput("burst_busy_cycles", n_busy - b_busy, 15);
    checkOutput("burst_starts", n_start - b_start, 3);
    checkOutput("burst_done_pulses", n_done - b_done, 1);
    checkOutput("burst_done_at_cnt4", n_done4 - b_done4, 1);

    $display("[TB] burst_count zero");
    applyStimulus(1'b1, 1'b1, 5, 0, 0, 3, 2, 4);
    b_busy = n_busy;
    trigger = 1'b1; ticks(5); trigger = 1'b0;
    ticks(2);
    checkOutput("bc0_stays_idle", n_busy - b_busy, 0);

    $display("[TB] period zero");
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 3, 2, 4);
    ticks(3);
    b_start = n_start; b_busy = n_busy;
    ticks(8);
    checkOutput("p0_starts", n_start - b_start, 8);
    checkOutput("p0_busy", n_busy - b_busy, 8);
    enable = 1'b0;
    ticks(3);

    $display("[TB] truncated window and zero width");
    applyStimulus(1'b1, 1'b0, 10, 0, 8, 2, 5, 0);
    ticks(5);
    b_v0 = n_v[0]; b_v1 = n_v[1];
    ticks(30);
    checkOutput("trunc_valid0_high", n_v[0] - b_v0, 6);
    checkOutput("width0_valid1_high", n_v[1] - b_v1, 0);
    enable = 1'b0;
    ticks(12);

    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 1'b1, 5, 3, 0, 3, 2, 4);
    trigger = 1'b1; tick(); trigger = 1'b0;
    waitCnt(2, 20);
    b_done = n_done;
    rst = 1'b1;
    tick();
    checkOutput("reset_midburst_outputs", int'({valid, start, busy, done, cnt}), 0);
    rst = 1'b0;
    enable = 1'b0;
    ticks(5);
    checkOutput("reset_midburst_no_done", n_done - b_done, 0);

    $display("[TB] randomized");
    for (int s = 0; s < 60; s++) begin
      applyStimulus($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
                    int'($urandom_range(12, 0)), int'($urandom_range(4, 0)),
                    int'($urandom_range(14, 0)), int'($urandom_range(14, 0)),
                    int'($urandom_range(8, 0)), int'($urandom_range(8, 0)));
      rst = ($urandom_range(24, 0) == 0);
      for (int t = 0; t < int'($urandom_range(15, 1)); t++) begin
        trigger = ($urandom_range(3, 0) == 0);
        tick();
        rst = 1'b0;
      end
    end
    enable  = 1'b0;
    trigger = 1'b0;
    ticks(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_pulse_generator.md
Name: multi_pulse_generator

Overview:
- Parametrised successor to the single-channel periodic pulse generator.
- One shared period counter drives N_CHANNELS gated outputs, each with its own delay and width inside the period.
- Adds a continuous/burst mode, a trigger, and shadowed configuration updated only at period boundaries.
- Sits between the config/status register bank and DAC/ADC gating or acquisition-start logic.

Parameters:
- N_CHANNELS, 2, number of independent pulse outputs
- PULSE_WIDTH_WIDTH, 8, width of each per-channel pulse width field
- PULSE_PERIOD_WIDTH, 16, width of period, delay and counter
- BURST_WIDTH, 16, width of burst period count

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  master run enable
- mode  input  1  0 = continuous, 1 = burst
- trigger  input  1  burst start request, level-sampled each cycle
- pulse_period  input  PULSE_PERIOD_WIDTH  period in cycles
- burst_count  input  BURST_WIDTH  periods per burst
- pulse_delay  input  N_CHANNELS*PULSE_PERIOD_WIDTH  per-channel start offset; channel i in slice i
- pulse_width  input  N_CHANNELS*PULSE_WIDTH_WIDTH  per-channel high time; channel i in slice i
- valid  output  N_CHANNELS  per-channel pulse outputs
- start  output  1  one-cycle marker at counter value 0
- cnt  output  PULSE_PERIOD_WIDTH  registered counter value
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse at burst end

Behaviour:
- Reset: state IDLE; counter, period counter and shadows cleared. valid=0, start=0, cnt=0, busy=0, done=0 on the edge after rst is sampled high.
- Reset mid-burst aborts immediately with no done pulse.
- States: IDLE and RUN.
- IDLE → RUN (continuous): enable=1 and mode=0.
- IDLE → RUN (burst): enable=1, mode=1, trigger=1 and burst_count≠0.
- On the IDLE → RUN edge:
  - counter ← 0, period counter ← 0.
  - Shadows ← pulse_period, pulse_delay, pulse_width, burst_count, mode.
- Effective period P = shadow period, except shadow period 0 is treated as 1 (counter stuck at 0, start every cycle).
- RUN counter: increments; at counter == P-1 it wraps to 0. On each wrap:
  - shadows reload from the inputs (mode excepted);
  - the period counter increments.
- Shadowed mode holds for the whole run; a mode change takes effect only after returning to IDLE.
- Continuous RUN:
  - enable=0 is honoured only at the wrap; the current period always completes, then state → IDLE.
  - done stays 0.
- Burst RUN:
  - on the wrap completing period number burst_count, state → IDLE;
  - done=1 for one cycle, aligned with the output cycle of the final counter value;
  - enable=0 mid-burst also stops at the next wrap, with done asserted.
- trigger in RUN is ignored; bursts do not retrigger or queue.
- trigger with burst_count=0 is ignored; the block stays IDLE.
- Outputs are registered, 1-cycle latency from internal counter value k:
  - cnt = k;
  - start = (k == 0);
  - busy = 1;
  - valid[i] = (k ≥ delay_i) and (k < delay_i + width_i).
- The delay + width sum is computed in PULSE_PERIOD_WIDTH+1 bits, so there is no wrap-around. Windows extending past P-1 are truncated at the period end and do not spill into the next period.
- width_i = 0 gives valid[i] always low. delay_i ≥ P gives valid[i] always low.
- In IDLE the outputs are valid=0, start=0, cnt=0, busy=0.

Optional Feature:
- Macro: MULTI_PULSE_GENERATOR_POLARITY_EN.
- Defined:
  - adds input pulse_polarity, width N_CHANNELS;
  - each valid[i] is XORed with a shadowed polarity bit, shadowed at the same instants as the other config;
  - inverted channels idle high in IDLE and after reset.
- Undefined:
  - no port;
  - all outputs are active-high and idle low.

Test Plan:
- Continuous basic, N=2:
  - stimulus: P=10; delay={0,3}; width={2,4}; enable=1.
  - response: start every 10 cycles.
  - response: valid[0] high at cnt 0-1, valid[1] high at cnt 3-6, repeating.
  - response: cnt runs 0..9.
- Burst:
  - stimulus: mode=1, burst_count=3, P=5, one-cycle trigger.
  - response: busy high exactly 15 cycles.
  - response: exactly 3 start pulses.
  - response: done one cycle, coincident with cnt=4 of period 3.
  - stimulus: second trigger mid-burst.
  - response: ignored.
- Shadowing:
  - stimulus: change P 10→6 and width[0] 2→5 at cnt=4.
  - response: current period still ends at cnt=9.
  - response: next period uses P=6, width 5.
- Edge configs:
  - stimulus: P=0.
  - response: start constant 1, cnt=0.
  - stimulus: delay=8, width=5, P=10.
  - response: valid high cnt 8-9 only, no spill into next period.
  - stimulus: width=0.
  - response: valid never high.
  - stimulus: burst_count=0 with trigger.
  - response: stays IDLE.
- Stop/reset:
  - stimulus: continuous enable drop at cnt=3, P=8.
  - response: runs through cnt=7, then busy=0.
  - stimulus: rst at cnt=2 of a burst.
  - response: all outputs 0 the next cycle, no done.
- Polarity (macro defined):
  - stimulus: pulse_polarity[1]=1.
  - response: valid[1] idles high and is low only inside its window.
